// File: rtl/rob_pkg.sv
// Shared sizing constants and entry-state encoding for the reorder buffer.
// Bypass of same-cycle CDB results into lookups is enabled by ROB_BYPASS_EN.
package rob_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int TAG_W     = $clog2(ROB_DEPTH);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rob_state_e;
endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, lookup and commit bundle between the core and the reorder buffer.
// The ROB side is the slave; the pipeline/testbench side is the master.
interface reorder_buffer_if #(
    parameter int DATA_W = rob_pkg::DATA_W,
    parameter int REG_W  = rob_pkg::REG_W,
    parameter int TAG_W  = rob_pkg::TAG_W
) ();
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;

    logic [TAG_W-1:0]  q_tag1;
    logic [TAG_W-1:0]  q_tag2;
    logic              q_ready1;
    logic              q_ready2;
    logic [DATA_W-1:0] q_value1;
    logic [DATA_W-1:0] q_value2;

    logic              commit_valid;
    logic [REG_W-1:0]  commit_rd;
    logic [DATA_W-1:0] commit_value;
    logic [TAG_W-1:0]  commit_tag;
    logic [TAG_W:0]    count;

    modport master (
        output issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_value,
        output q_tag1, q_tag2,
        input  issue_ready, issue_tag, q_ready1, q_ready2,
        input  q_value1, q_value2,
        input  commit_valid, commit_rd, commit_value, commit_tag, count
    );

    modport slave (
        input  issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_value,
        input  q_tag1, q_tag2,
        output issue_ready, issue_tag, q_ready1, q_ready2,
        output q_value1, q_value2,
        output commit_valid, commit_rd, commit_value, commit_tag, count
    );
endinterface

// File: rtl/rob_lookup_port.sv
// One operand lookup into the ROB; optional same-cycle CDB forwarding.
// Forwarding is compiled in only when ROB_BYPASS_EN is defined.
module rob_lookup_port #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
) (
    input  logic [TAG_W-1:0]   i_q_tag,
    input  rob_pkg::rob_state_e i_state,
    input  logic [DATA_W-1:0]  i_value,
    input  logic               i_cdb_valid,
    input  logic [TAG_W-1:0]   i_cdb_tag,
    input  logic [DATA_W-1:0]  i_cdb_value,
    output logic               o_ready,
    output logic [DATA_W-1:0]  o_value
);
    import rob_pkg::*;

    logic w_hit;

`ifdef ROB_BYPASS_EN
    assign w_hit = i_cdb_valid && (i_cdb_tag == i_q_tag) && (i_state == BUSY);
`else
    logic w_unused;
    assign w_unused = ^{i_cdb_valid, i_cdb_tag, i_q_tag, i_cdb_value};
    assign w_hit    = 1'b0;
`endif

    always_comb begin
        o_ready = (i_state == DONE) || w_hit;
        o_value = '0;
        if (i_state == DONE) begin
            o_value = i_value;
        end else if (w_hit) begin
            o_value = i_cdb_value;
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB complete,
// in-order single-entry retire. ROB_BYPASS_EN enables lookup forwarding.
module reorder_buffer #(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int DATA_W    = rob_pkg::DATA_W,
    parameter int REG_W     = rob_pkg::REG_W
) (
    input logic CLK,
    input logic RST,
    reorder_buffer_if.slave bus
);
    import rob_pkg::*;

    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = TAG_W + 1;

    rob_state_e        r_state [ROB_DEPTH];
    logic [REG_W-1:0]  r_rd    [ROB_DEPTH];
    logic [DATA_W-1:0] r_value [ROB_DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_commit_valid;
    logic [REG_W-1:0]  r_commit_rd;
    logic [DATA_W-1:0] r_commit_value;
    logic [TAG_W-1:0]  r_commit_tag;

    logic w_issue_ready;
    logic w_issue;
    logic w_cdb;
    logic w_commit;

    // Readiness ignores a same-cycle retire so the issue path stays short.
    assign w_issue_ready = (r_count != CNT_W'(ROB_DEPTH));
    assign w_issue  = bus.issue_valid && w_issue_ready;
    assign w_cdb    = bus.cdb_valid && (r_state[bus.cdb_tag] == BUSY);
    assign w_commit = (r_state[r_head] == DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_state[i] <= FREE;
                r_rd[i]    <= '0;
                r_value[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_value <= '0;
            r_commit_tag   <= '0;
        end else begin
            // Head is DONE, CDB target is BUSY, tail is FREE: never the same slot.
            if (w_commit) begin
                r_state[r_head] <= FREE;
                r_head          <= r_head + TAG_W'(1);
                r_commit_rd     <= r_rd[r_head];
                r_commit_value  <= r_value[r_head];
                r_commit_tag    <= r_head;
            end
            if (w_cdb) begin
                r_state[bus.cdb_tag] <= DONE;
                r_value[bus.cdb_tag] <= bus.cdb_value;
            end
            if (w_issue) begin
                r_state[r_tail] <= BUSY;
                r_rd[r_tail]    <= bus.issue_rd;
                r_value[r_tail] <= '0;
                r_tail          <= r_tail + TAG_W'(1);
            end
            r_commit_valid <= w_commit;
            unique case ({w_issue, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    rob_lookup_port #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_lookup1 (
        .i_q_tag    (bus.q_tag1),
        .i_state    (r_state[bus.q_tag1]),
        .i_value    (r_value[bus.q_tag1]),
        .i_cdb_valid(bus.cdb_valid),
        .i_cdb_tag  (bus.cdb_tag),
        .i_cdb_value(bus.cdb_value),
        .o_ready    (bus.q_ready1),
        .o_value    (bus.q_value1)
    );

    rob_lookup_port #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_lookup2 (
        .i_q_tag    (bus.q_tag2),
        .i_state    (r_state[bus.q_tag2]),
        .i_value    (r_value[bus.q_tag2]),
        .i_cdb_valid(bus.cdb_valid),
        .i_cdb_tag  (bus.cdb_tag),
        .i_cdb_value(bus.cdb_value),
        .o_ready    (bus.q_ready2),
        .o_value    (bus.q_value2)
    );

    assign bus.issue_ready  = w_issue_ready;
    assign bus.issue_tag    = r_tail;
    assign bus.count        = r_count;
    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_rd    = r_commit_rd;
    assign bus.commit_value = r_commit_value;
    assign bus.commit_tag   = r_commit_tag;
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 8, meaning number of entries; the value is a power of two.
REQ-002 SHALL have parameter DATA_W, default 32, meaning result width.
REQ-003 SHALL have parameter REG_W, default 5, meaning architectural register index width.
REQ-004 SHALL have port CLK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port issue_valid  input  1  meaning request to allocate an entry.
REQ-007 SHALL have port issue_rd  input  REG_W  meaning destination register of the issuing instruction.
REQ-008 SHALL have port issue_ready  output  1  meaning an entry is free (count < ROB_DEPTH).
REQ-009 SHALL have port issue_tag  output  log2(ROB_DEPTH)  meaning the tag (tail index) the next allocation receives.
REQ-010 SHALL have port cdb_valid  input  1  meaning a common-data-bus broadcast is present.
REQ-011 SHALL have port cdb_tag  input  log2(ROB_DEPTH)  meaning producer tag of the broadcast.
REQ-012 SHALL have port cdb_value  input  DATA_W  meaning broadcast result.
REQ-013 SHALL have ports q_tag1 and q_tag2  input  log2(ROB_DEPTH)  meaning operand lookup tags.
REQ-014 SHALL have ports q_ready1 and q_ready2  output  1  meaning the looked-up entry is DONE.
REQ-015 SHALL have ports q_value1 and q_value2  output  DATA_W  meaning the looked-up entry value; 0 when not ready.
REQ-016 SHALL have port commit_valid  output  1  meaning an in-order retirement this cycle (registered).
REQ-017 SHALL have port commit_rd  output  REG_W  meaning destination register of the retiring entry.
REQ-018 SHALL have port commit_value  output  DATA_W  meaning value of the retiring entry.
REQ-019 SHALL have port commit_tag  output  log2(ROB_DEPTH)  meaning tag of the retiring entry.
REQ-020 SHALL have port count  output  log2(ROB_DEPTH)+1  meaning number of occupied entries.

Function
REQ-021 Each entry SHALL hold state FREE, BUSY or DONE, plus rd and value fields.
REQ-022 On an edge with issue_valid=1 and issue_ready=1, entry[tail] SHALL become BUSY with rd=issue_rd and value=0, and tail SHALL increment modulo ROB_DEPTH.
REQ-023 issue_valid while issue_ready=0 SHALL be ignored, with no state change; issue_ready SHALL NOT account for a same-cycle commit.
REQ-024 On an edge with cdb_valid=1 and entry[cdb_tag] BUSY, that entry SHALL become DONE with value=cdb_value; a broadcast to a FREE or DONE entry SHALL be ignored.
REQ-025 On each edge where entry[head] is DONE, the block SHALL register commit_valid=1 with rd, value and tag, free the entry, and increment head modulo ROB_DEPTH; otherwise commit_valid SHALL be 0 the following cycle.
REQ-026 At most one commit per cycle; minimum latency from cdb_valid to commit_valid SHALL be 2 edges, with DONE at edge N and commit visible after edge N+1.
REQ-027 Issue, CDB write and commit in the same cycle SHALL all take effect; count SHALL change by +1, 0 or -1 accordingly.
REQ-028 Lookup outputs SHALL be combinational from entry state.

Reset
REQ-029 When RST=1 at an edge, all entries SHALL become FREE and head, tail and count SHALL become 0; commit_valid, commit_rd, commit_value and commit_tag SHALL become 0; issue_ready=1 and issue_tag=0 SHALL follow. Reset SHALL take priority over issue, CDB and commit in progress.

Configuration
REQ-030 With ROB_BYPASS_EN defined, a lookup whose q_tag equals cdb_tag while cdb_valid=1 and the entry is BUSY SHALL return ready=1 and value=cdb_value in the same cycle.
REQ-031 Without ROB_BYPASS_EN, that lookup SHALL return ready=0 until the cycle after the CDB write.

Structure
REQ-032 Package rob_pkg SHALL hold ROB_DEPTH, DATA_W, REG_W, the TAG_W constant and the entry-state enum (FREE, BUSY, DONE).
REQ-033 Sub-module rob_lookup_port SHALL implement one lookup (with optional bypass) and be instantiated twice.

Verification
REQ-034 Reset then issue rd=3, rd=7 -> issue_tag 0 then 1, count=2, no commit.
REQ-035 CDB tag=1 value=0xAA, then tag=0 value=0x55 -> no commit after the first; after the second, commits in order: tag0/rd3/0x55, then tag1/rd7/0xAA on consecutive cycles.
REQ-036 Issue 8 times without CDB -> issue_ready=0, count=8; a 9th issue is ignored; after retiring tag0, issue_tag wraps to 0.
REQ-037 CDB to a FREE tag 5 with value 0x1234 -> no state change and no commit.
REQ-038 q_tag1=2 with same-cycle CDB tag 2 value 0x99 -> q_ready1=1 and q_value1=0x99 with ROB_BYPASS_EN; q_ready1=0 without it.
REQ-039 RST asserted with 4 BUSY and 1 DONE entries -> next cycle count=0, commit_valid=0, issue_tag=0.
